sap_mem_unit: RTL

//  Parametrised memory block for the SAP-style CPU: memory address register (MAR) plus a

---
 rtl/sap_pkg.sv | 15 +
 rtl/sap_mem_unit_if.sv | 31 +++
 rtl/sap_ram.sv | 46 ++++
 rtl/sap_mem_unit.sv | 110 +++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-style CPU blocks.
//  BUS_W   : width of the shared CPU bus. The register and ALU blocks use it too.
//  state_e : memory-unit mode. S_RUN is normal bus operation. S_PROG is loader filling.
//            S_FULL means the loader has written every word.
package sap_pkg;

  localparam int unsigned BUS_W = 8;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_PROG = 2'd1,
    S_FULL = 2'd2
  } state_e;

endpackage

// File: rtl/sap_mem_unit_if.sv
// Bus, control and loader signals of the SAP memory unit.
//  master : drives the controls, bus_in and the loader beat. This is the CPU or bench side.
//  slave  : the memory unit. It returns prog_ready/prog_done, data_out, bus_oe and addr_out.
interface sap_mem_unit_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) ();

  logic              prog_mode;
  logic              n_load_addr;
  logic              n_load_data;
  logic              n_out_en;
  logic [DATA_W-1:0] bus_in;
  logic              prog_valid;
  logic              prog_ready;
  logic              prog_done;
  logic [DATA_W-1:0] data_out;
  logic              bus_oe;
  logic [ADDR_W-1:0] addr_out;

  modport master (
    output prog_mode, n_load_addr, n_load_data, n_out_en, bus_in, prog_valid,
    input  prog_ready, prog_done, data_out, bus_oe, addr_out
  );

  modport slave (
    input  prog_mode, n_load_addr, n_load_data, n_out_en, bus_in, prog_valid,
    output prog_ready, prog_done, data_out, bus_oe, addr_out
  );

endinterface

// File: rtl/sap_ram.sv
// DEPTH x DATA_W RAM with one synchronous write port and one registered read port.
//  i_clk, i_rst : clock and synchronous active-high reset. Reset clears only the read register.
//  i_we, i_waddr, i_wdata : write port.
//  i_raddr, i_rvalid : read address. When i_rvalid=0 the address is out of range and the
//                      read returns 0.
//  o_rdata : registered read data. There is no write-to-read bypass.
module sap_ram
  import sap_pkg::*;
#(
  parameter int unsigned DATA_W = BUS_W,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic              i_rvalid,
  output logic [DATA_W-1:0] o_rdata
);

  // Contents are deliberately not reset.
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_rvalid) begin
      r_rdata <= r_mem[i_raddr];
    end else begin
      r_rdata <= '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sap_mem_unit.sv
// SAP memory unit. It holds the MAR, the loader pointer and the mode FSM, and contains a sap_ram.
//  i_clk, i_rst : clock and synchronous active-high reset.
//  mem_if       : the slave side of sap_mem_unit_if.
//   - Run mode   : n_load_addr, n_load_data and n_out_en act on the bus.
//   - Program mode : a valid/ready loader writes RAM from address 0 upward.
//  Outputs: data_out is registered RAM[MAR], bus_oe is registered, addr_out is the MAR.
module sap_mem_unit
  import sap_pkg::*;
#(
  parameter int unsigned DATA_W = BUS_W,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 1 << ADDR_W
) (
  input logic           i_clk,
  input logic           i_rst,
  sap_mem_unit_if.slave mem_if
);

  localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DepthW  = (ADDR_W + 1)'(DEPTH);

  state_e            r_state;
  state_e            w_state_d;
  logic [ADDR_W-1:0] r_mar;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_bus_oe;

  logic              w_run;
  logic              w_prog_ready;
  logic              w_accept;
  logic              w_mar_ok;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_rdata;

  always_comb begin
    w_run        = (r_state == S_RUN);
    w_prog_ready = (r_state == S_PROG) & ~i_rst;
    w_accept     = w_prog_ready & mem_if.prog_valid;
    // Addresses at or above DEPTH do not exist. Writes to them are dropped and reads return 0.
    w_mar_ok     = ({1'b0, r_mar} < DepthW);
    // The write uses the MAR value from before the edge. A simultaneous address load only
    // affects later cycles.
    w_we         = w_accept | (w_run & ~i_rst & ~mem_if.n_load_data & w_mar_ok);
    w_waddr      = w_accept ? r_ptr : r_mar;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      S_RUN: begin
        if (mem_if.prog_mode) w_state_d = S_PROG;
      end
      S_PROG: begin
        if (!mem_if.prog_mode) begin
          w_state_d = S_RUN;
        end else if (w_accept && (r_ptr == LastPtr)) begin
          w_state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (!mem_if.prog_mode) w_state_d = S_RUN;
      end
      default: w_state_d = S_RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_RUN;
      r_mar    <= '0;
      r_ptr    <= '0;
      r_bus_oe <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_bus_oe <= w_run & ~mem_if.n_out_en;
      if (w_run && !mem_if.n_load_addr) begin
        r_mar <= mem_if.bus_in[ADDR_W-1:0];
      end
      // Each session restarts at 0. The pointer stays at the last word once full.
      if (w_state_d == S_RUN) begin
        r_ptr <= '0;
      end else if (w_accept && (w_state_d == S_PROG)) begin
        r_ptr <= r_ptr + 1'b1;
      end
    end
  end

  sap_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_we     (w_we),
    .i_waddr  (w_waddr),
    .i_wdata  (mem_if.bus_in),
    .i_raddr  (r_mar),
    .i_rvalid (w_mar_ok),
    .o_rdata  (w_rdata)
  );

  assign mem_if.prog_ready = w_prog_ready;
  assign mem_if.prog_done  = (r_state == S_FULL);
  assign mem_if.data_out   = w_rdata;
  assign mem_if.bus_oe     = r_bus_oe;
  assign mem_if.addr_out   = r_mar;

endmodule
